// File: rtl/ac_table_writer_if.sv
// Host record stream plus goto/failure table write ports for the Aho-Corasick table loader.
interface ac_table_writer_if #(
    parameter int unsigned AW = 5
);
    logic          start;
    logic [7:0]    din;
    logic          din_valid;
    logic          din_ready;
    logic          goto_we;
    logic [AW-1:0] goto_addr;
    logic [7:0]    goto_cur;
    logic [3:0]    goto_chara;
    logic [7:0]    goto_next;
    logic          fail_we;
    logic [AW-1:0] fail_addr;
    logic [7:0]    fail_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   goto_count;

    modport master (
        output start, din, din_valid,
        input  din_ready, goto_we, goto_addr, goto_cur, goto_chara, goto_next,
        input  fail_we, fail_addr, fail_data, busy, done, err, goto_count
    );

    modport slave (
        input  start, din, din_valid,
        output din_ready, goto_we, goto_addr, goto_cur, goto_chara, goto_next,
        output fail_we, fail_addr, fail_data, busy, done, err, goto_count
    );
endinterface

// File: rtl/ac_table_writer.sv
// Aho-Corasick table loader: clears goto/failure RAMs, then writes records parsed
// from a byte-serial stream (0x01 goto, 0x02 failure, 0xFF end).
module ac_table_writer #(
    parameter int unsigned GOTO_DEPTH = 32,
    parameter int unsigned FAIL_DEPTH = 32,
    parameter int unsigned AW         = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    ac_table_writer_if.slave   bus
);

    localparam int unsigned CLR_DEPTH = (GOTO_DEPTH > FAIL_DEPTH) ? GOTO_DEPTH : FAIL_DEPTH;
    localparam int unsigned CW        = AW + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_CMD, S_G0, S_G1, S_G2, S_GW, S_F0, S_F1, S_FW, S_FIN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] clr_q, clr_d;
    logic [7:0]    cur_q, cur_d;
    logic [7:0]    chara_q, chara_d;
    logic [7:0]    fst_q, fst_d;

    logic          ready_q, ready_d;
    logic          gwe_q, gwe_d;
    logic [AW-1:0] gaddr_q, gaddr_d;
    logic [7:0]    gcur_q, gcur_d;
    logic [3:0]    gchara_q, gchara_d;
    logic [7:0]    gnext_q, gnext_d;
    logic          fwe_q, fwe_d;
    logic [AW-1:0] faddr_q, faddr_d;
    logic [7:0]    fdata_q, fdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW:0]   gcnt_q, gcnt_d;

    logic          accept;
    logic          clr_wr;
    logic [CW-1:0] clr_idx;

    assign accept = bus.din_valid && ready_q;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            clr_q    <= '0;
            cur_q    <= '0;
            chara_q  <= '0;
            fst_q    <= '0;
            ready_q  <= 1'b0;
            gwe_q    <= 1'b0;
            gaddr_q  <= '0;
            gcur_q   <= '0;
            gchara_q <= '0;
            gnext_q  <= '0;
            fwe_q    <= 1'b0;
            faddr_q  <= '0;
            fdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            gcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            clr_q    <= clr_d;
            cur_q    <= cur_d;
            chara_q  <= chara_d;
            fst_q    <= fst_d;
            ready_q  <= ready_d;
            gwe_q    <= gwe_d;
            gaddr_q  <= gaddr_d;
            gcur_q   <= gcur_d;
            gchara_q <= gchara_d;
            gnext_q  <= gnext_d;
            fwe_q    <= fwe_d;
            faddr_q  <= faddr_d;
            fdata_q  <= fdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            gcnt_q   <= gcnt_d;
        end
    end

    // Next state and next output values; write strobes are single-cycle pulses
    always_comb begin
        state_d  = state_q;
        clr_d    = clr_q;
        cur_d    = cur_q;
        chara_d  = chara_q;
        fst_d    = fst_q;
        gwe_d    = 1'b0;
        gaddr_d  = gaddr_q;
        gcur_d   = gcur_q;
        gchara_d = gchara_q;
        gnext_d  = gnext_q;
        fwe_d    = 1'b0;
        faddr_d  = faddr_q;
        fdata_d  = fdata_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        gcnt_d   = gcnt_q;
        clr_wr   = 1'b0;
        clr_idx  = '0;

        unique case (state_q)
            S_IDLE, S_FIN: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                    clr_wr  = 1'b1;
                    clr_idx = '0;
                    clr_d   = CW'(1);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    gcnt_d  = '0;
                end
            end
            S_CLEAR: begin
                if (clr_q == CW'(CLR_DEPTH)) begin
                    state_d = S_CMD;
                end else begin
                    clr_wr  = 1'b1;
                    clr_idx = clr_q;
                    clr_d   = clr_q + CW'(1);
                end
            end
            S_CMD: begin
                if (accept) begin
                    unique case (bus.din)
                        8'h01:   state_d = S_G0;
                        8'h02:   state_d = S_F0;
                        8'hFF: begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_G0: begin
                if (accept) begin
                    cur_d   = bus.din;
                    state_d = S_G1;
                end
            end
            S_G1: begin
                if (accept) begin
                    chara_d = bus.din;
                    state_d = S_G2;
                end
            end
            S_G2: begin
                // Write is launched on the last byte so the strobe lands in GW
                if (accept) begin
                    state_d = S_GW;
                    if (chara_q[7:4] == 4'd0 && 32'(gcnt_q) < GOTO_DEPTH) begin
                        gwe_d    = 1'b1;
                        gaddr_d  = AW'(gcnt_q);
                        gcur_d   = cur_q;
                        gchara_d = chara_q[3:0];
                        gnext_d  = bus.din;
                        gcnt_d   = gcnt_q + (AW+1)'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_GW: state_d = S_CMD;
            S_F0: begin
                if (accept) begin
                    fst_d   = bus.din;
                    state_d = S_F1;
                end
            end
            S_F1: begin
                // Failure states are 1-based in the stream; the table is 0-based
                if (accept) begin
                    state_d = S_FW;
                    if (fst_q == 8'd0 || 32'(fst_q) > FAIL_DEPTH) begin
                        err_d = 1'b1;
                    end else begin
                        fwe_d   = 1'b1;
                        faddr_d = AW'(fst_q - 8'd1);
                        fdata_d = bus.din;
                    end
                end
            end
            S_FW:    state_d = S_CMD;
            default: state_d = S_IDLE;
        endcase

        if (clr_wr) begin
            gwe_d    = 32'(clr_idx) < GOTO_DEPTH;
            fwe_d    = 32'(clr_idx) < FAIL_DEPTH;
            gaddr_d  = AW'(clr_idx);
            faddr_d  = AW'(clr_idx);
            gcur_d   = 8'hFF;
            gchara_d = 4'd0;
            gnext_d  = 8'd0;
            fdata_d  = 8'd0;
        end
    end

    always_comb begin
        unique case (state_d)
            S_CMD, S_G0, S_G1, S_G2, S_F0, S_F1: ready_d = 1'b1;
            default:                             ready_d = 1'b0;
        endcase
    end

    assign bus.din_ready  = ready_q;
    assign bus.goto_we    = gwe_q;
    assign bus.goto_addr  = gaddr_q;
    assign bus.goto_cur   = gcur_q;
    assign bus.goto_chara = gchara_q;
    assign bus.goto_next  = gnext_q;
    assign bus.fail_we    = fwe_q;
    assign bus.fail_addr  = faddr_q;
    assign bus.fail_data  = fdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.goto_count = gcnt_q;

endmodule

// File: tb/tb_ac_table_writer.sv
// Scoreboard bench for ac_table_writer: directed record streams, expected table
// writes queued at issue time and matched by a free-running write monitor.
module tb_ac_table_writer;

    localparam int unsigned AW = 5;
    localparam int unsigned D  = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ac_table_writer_if #(.AW(AW)) bus ();

    ac_table_writer #(.GOTO_DEPTH(32), .FAIL_DEPTH(32), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         kind;   // 0 clear, 1 goto, 2 failure
        logic [4:0] addr;
        logic [7:0] cur;
        logic [3:0] chara;
        logic [7:0] nxt;
        logic [7:0] fdata;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void push_exp(input int k, input logic [4:0] a, input logic [7:0] c,
                                     input logic [3:0] ch, input logic [7:0] n, input logic [7:0] f);
        exp_t e;
        e.kind = k; e.addr = a; e.cur = c; e.chara = ch; e.nxt = n; e.fdata = f;
        sb.push_back(e);
    endfunction

    // Write monitor
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (rst_n && (bus.goto_we || bus.fail_we)) begin
            k = (bus.goto_we && bus.fail_we) ? 0 : (bus.goto_we ? 1 : 2);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: kind %0d goto_addr %0h fail_addr %0h with nothing expected",
                         k, bus.goto_addr, bus.fail_addr);
            end else begin
                e = sb.pop_front();
                chk("wr_kind", 32'(k), 32'(e.kind));
                if (e.kind != 2) begin
                    chk("goto_addr",  32'(bus.goto_addr),  32'(e.addr));
                    chk("goto_cur",   32'(bus.goto_cur),   32'(e.cur));
                    chk("goto_chara", 32'(bus.goto_chara), 32'(e.chara));
                    chk("goto_next",  32'(bus.goto_next),  32'(e.nxt));
                end
                if (e.kind != 1) begin
                    chk("fail_addr", 32'(bus.fail_addr), 32'(e.addr));
                    chk("fail_data", 32'(bus.fail_data), 32'(e.fdata));
                end
                if (e.kind != 0) chk("ready_low_in_write", 32'(bus.din_ready), 32'(0));
            end
        end
    end

    // Offers one byte; returns (at posedge+1) with the cycle number of the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit gappy, output int acc_cyc);
        int n = 0;
        if (gappy) begin
            repeat ($urandom_range(0, 3)) begin
                bus.din_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.din       = b;
        bus.din_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.din_ready && n < 200);
        if (!bus.din_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %0h not accepted within 200 cycles", b);
        end
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic send_goto(input logic [7:0] c, input logic [7:0] ch, input logic [7:0] n,
                             input bit gappy, output int first_cyc);
        int t;
        send_byte(8'h01, gappy, first_cyc);
        send_byte(c, gappy, t);
        send_byte(ch, gappy, t);
        send_byte(n, gappy, t);
    endtask

    task automatic send_fail(input logic [7:0] s, input logic [7:0] f, input bit gappy);
        int t;
        send_byte(8'h02, gappy, t);
        send_byte(s, gappy, t);
        send_byte(f, gappy, t);
    endtask

    // Pulses START, queues the clear writes and checks the clear window timing
    task automatic start_pass();
        int bad = 0;
        for (int i = 0; i < int'(D); i++) push_exp(0, 5'(i), 8'hFF, 4'd0, 8'd0, 8'd0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= int'(D) + 1; i++) begin
            @(negedge clk);
            if (i <= int'(D)) begin
                if (!(bus.goto_we && bus.fail_we && bus.busy && !bus.din_ready)) bad++;
            end else begin
                chk("cmd_ready_after_clear", 32'(bus.din_ready), 32'(1));
            end
        end
        chk("clear_window", 32'(bad), 32'(0));
        @(posedge clk); #1;
    endtask

    task automatic finish_pass(input int exp_count, input bit exp_err);
        int t;
        send_byte(8'hFF, 1'b0, t);
        @(negedge clk);
        chk("done",       32'(bus.done),       32'(1));
        chk("busy_fin",   32'(bus.busy),       32'(0));
        chk("ready_fin",  32'(bus.din_ready),  32'(0));
        chk("goto_count", 32'(bus.goto_count), 32'(exp_count));
        chk("err",        32'(bus.err),        32'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_goto_we"},    32'(bus.goto_we),    32'(0));
        chk({tag, "_fail_we"},    32'(bus.fail_we),    32'(0));
        chk({tag, "_din_ready"},  32'(bus.din_ready),  32'(0));
        chk({tag, "_busy"},       32'(bus.busy),       32'(0));
        chk({tag, "_done"},       32'(bus.done),       32'(0));
        chk({tag, "_err"},        32'(bus.err),        32'(0));
        chk({tag, "_goto_count"}, 32'(bus.goto_count), 32'(0));
        chk({tag, "_goto_addr"},  32'(bus.goto_addr),  32'(0));
        chk({tag, "_fail_data"},  32'(bus.fail_data),  32'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c32, t;
        bus.start     = 1'b0;
        bus.din       = 8'h00;
        bus.din_valid = 1'b0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single goto record then end
        start_pass();
        push_exp(1, 5'd0, 8'h00, 4'h1, 8'h01, 8'h00);
        send_goto(8'h00, 8'h01, 8'h01, 1'b0, t);
        finish_pass(1, 1'b0);

        // Failure records: valid, boundary state 32, state 0, state 33
        start_pass();
        push_exp(2, 5'd4, 8'h00, 4'h0, 8'h00, 8'h02);
        send_fail(8'h05, 8'h02, 1'b0);
        push_exp(2, 5'd31, 8'h00, 4'h0, 8'h00, 8'h09);
        send_fail(8'h20, 8'h09, 1'b0);
        @(negedge clk);
        chk("err_after_good_fail", 32'(bus.err), 32'(0));
        @(posedge clk); #1;
        send_fail(8'h00, 8'h03, 1'b0);
        @(negedge clk);
        chk("err_after_state0", 32'(bus.err), 32'(1));
        @(posedge clk); #1;
        send_fail(8'h21, 8'h07, 1'b0);
        finish_pass(0, 1'b1);

        // 33 back-to-back goto records; the last overflows the table
        start_pass();
        c0 = 0; c32 = 0;
        for (int i = 0; i < 33; i++) begin
            if (i < 32) push_exp(1, 5'(i), 8'(i), 4'(i % 16), 8'(i + 1), 8'h00);
            send_goto(8'(i), 8'(i % 16), 8'(i + 1), 1'b0, t);
            if (i == 0) c0 = t;
            if (i == 32) c32 = t;
            if (i == 31) begin
                @(negedge clk);
                chk("count_at_full", 32'(bus.goto_count), 32'(32));
                chk("err_before_overflow", 32'(bus.err), 32'(0));
            end
        end
        chk("cycles_per_goto_record", 32'(c32 - c0), 32'(32 * 5));
        finish_pass(32, 1'b1);

        // Bad chara, bad command, then a good record still lands
        start_pass();
        send_goto(8'h03, 8'h1A, 8'h04, 1'b0, t);
        @(negedge clk);
        chk("err_after_bad_chara", 32'(bus.err), 32'(1));
        @(posedge clk); #1;
        send_byte(8'h07, 1'b0, t);
        push_exp(1, 5'd0, 8'h02, 4'h3, 8'h04, 8'h00);
        send_goto(8'h02, 8'h03, 8'h04, 1'b0, t);
        finish_pass(1, 1'b1);

        // Random DIN_VALID gaps
        start_pass();
        for (int i = 0; i < 6; i++) begin
            push_exp(1, 5'(i), 8'(8'h40 + i), 4'(15 - i), 8'(8'h80 + i), 8'h00);
            send_goto(8'(8'h40 + i), 8'(15 - i), 8'(8'h80 + i), 1'b1, t);
            if (i == 2) begin
                push_exp(2, 5'd9, 8'h00, 4'h0, 8'h00, 8'h33);
                send_fail(8'h0A, 8'h33, 1'b1);
            end
        end
        push_exp(2, 5'd0, 8'h00, 4'h0, 8'h00, 8'hC5);
        send_fail(8'h01, 8'hC5, 1'b1);
        finish_pass(6, 1'b0);

        // Reset in G1 aborts the pass; next pass restarts from a clean state
        start_pass();
        send_byte(8'h07, 1'b0, t);
        push_exp(1, 5'd0, 8'h05, 4'h6, 8'h07, 8'h00);
        send_goto(8'h05, 8'h06, 8'h07, 1'b0, t);
        send_byte(8'h01, 1'b0, t);
        send_byte(8'h05, 1'b0, t);
        bus.din       = 8'h0E;
        bus.din_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        bus.din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy_after_abort",  32'(bus.busy),      32'(0));
        chk("idle_ready_after_abort", 32'(bus.din_ready), 32'(0));
        start_pass();
        push_exp(1, 5'd0, 8'h09, 4'h2, 8'h08, 8'h00);
        send_goto(8'h09, 8'h02, 8'h08, 1'b0, t);
        finish_pass(1, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ac_table_writer.md
# ac_table_writer

Loader for the Aho-Corasick match tables. It accepts a byte-serial record stream and clears the goto and failure table memories, then fills them. These are the tables that table_reader scans at match time. It sits between the host/config interface and the four table RAMs (current_state_goto, chara_goto, next_state_goto, failure_state_failure), driving their write ports.

## Interface

Parameters:
- GOTO_DEPTH, 32, number of goto-table entries
- FAIL_DEPTH, 32, number of failure-table entries
- AW, 5, table address width; must satisfy 2^AW >= max(GOTO_DEPTH, FAIL_DEPTH)

Ports:
- CLK  in  1  system clock; single clock domain, rising edge
- RST  in  1  reset, asynchronous assert, active-low
- START  in  1  one-cycle pulse that begins a clear+load pass
- DIN  in  8  record stream byte
- DIN_VALID  in  1  DIN holds a valid byte
- DIN_READY  out  1  writer accepts DIN this cycle
- GOTO_WE  out  1  goto-table write strobe
- GOTO_ADDR  out  AW  goto-table write address
- GOTO_CUR  out  8  current-state field
- GOTO_CHARA  out  4  character field
- GOTO_NEXT  out  8  next-state field
- FAIL_WE  out  1  failure-table write strobe
- FAIL_ADDR  out  AW  failure-table write address
- FAIL_DATA  out  8  failure-state field
- BUSY  out  1  high from the cycle after START until DONE
- DONE  out  1  table load complete; level
- ERR  out  1  sticky error
- GOTO_COUNT  out  AW+1  goto entries written in this pass

## Operation

- A byte transfers when DIN_VALID and DIN_READY are both high at a rising CLK edge.
- DIN_READY is high only in CMD, G0–G2 and F0–F1.
- Record format, first byte is the command:
  - 0x01 goto record, followed by cur, chara, next.
  - 0x02 failure record, followed by state, fail.
  - 0xFF end of table.
- FSM states: IDLE, CLEAR, CMD, G0, G1, G2, GW, F0, F1, FW, FIN.
- IDLE/FIN + START -> CLEAR. In IDLE and FIN, START also clears ERR and GOTO_COUNT, and drops DONE.
- CLEAR:
  - Address counter runs 0..D-1, where D = max(GOTO_DEPTH, FAIL_DEPTH).
  - Each cycle asserts GOTO_WE for addresses < GOTO_DEPTH, with CUR=0xFF (an unused state), CHARA=0, NEXT=0.
  - Each cycle asserts FAIL_WE for addresses < FAIL_DEPTH, with DATA=0.
  - After address D-1 -> CMD.
- CMD, on each accepted byte:
  - 0x01 -> G0
  - 0x02 -> F0
  - 0xFF -> FIN
  - any other value: set ERR, discard the byte, stay in CMD.
- G0/G1/G2 latch cur/chara/next in turn, then go to GW.
  - If chara[7:4] != 0, the record is flagged bad.
- GW:
  - If the record is not bad and GOTO_COUNT < GOTO_DEPTH: GOTO_WE=1 at address GOTO_COUNT, then GOTO_COUNT increments.
  - Otherwise: ERR=1 and no write.
  - Next state: CMD.
- F0/F1 latch state/fail, then go to FW.
- FW:
  - FAIL_ADDR = state-1, matching the reader's failure indexing.
  - If state is 0 or state > FAIL_DEPTH: ERR=1 and no write.
  - Otherwise: FAIL_WE=1 with DATA=fail.
  - Next state: CMD.
- FIN: DONE=1, BUSY=0; holds until START.
- START outside IDLE/FIN is ignored.
- GOTO_CUR/CHARA/NEXT, FAIL_ADDR/DATA are don't-care when the matching WE is low. They must not be X while WE is high.

## Timing

- Reset: state=IDLE, DIN_READY=0, GOTO_WE=0, FAIL_WE=0, BUSY=0, DONE=0, ERR=0, GOTO_COUNT=0, all data/address outputs 0.
  - Table RAM contents are not touched by reset.
- Reset mid-pass aborts immediately to IDLE. A partial write is never issued after reset deasserts.
- START sampled in cycle T: CLEAR writes occupy T+1 .. T+D, and CMD with DIN_READY=1 starts at T+D+1.
- Goto record with DIN_VALID held high: 4 accepted bytes plus 1 GW cycle, 5 cycles per record.
  - GOTO_WE is high exactly one cycle, the cycle after the 4th byte.
- Failure record: 3 bytes plus 1 FW cycle, 4 cycles per record.
- End byte accepted in cycle E: DONE=1 from E+1.
- DIN_VALID low stalls in any collecting state indefinitely, with no timeout.
- GOTO_WE and FAIL_WE are never high in the same cycle, except during CLEAR.
- Outputs are registered.

## Test plan

- Reset, START, then 0x01 00 01 01 and 0xFF -> clear writes on 32 consecutive cycles, then one goto write at addr 0 with cur=0, chara=1, next=1; DONE=1, GOTO_COUNT=1, ERR=0.
- Failure record 0x02 05 02 -> FAIL_WE at FAIL_ADDR=4 with FAIL_DATA=2. Record 0x02 00 03 -> no write, ERR=1.
- 33 goto records, DIN_VALID held high -> 32 writes at addrs 0..31; the 33rd is dropped with ERR=1; GOTO_COUNT=32; each record takes 5 cycles.
- Goto record with chara=0x1A, and command byte 0x07 -> no write for either; ERR=1; FSM returns to CMD and the following valid record is written.
- DIN_VALID toggled randomly during records -> writes identical to the back-to-back case; DIN_READY is low in CLEAR, GW, FW and FIN.
- RST asserted during G1, then START -> all outputs at reset values; the new pass re-clears and GOTO_COUNT restarts at 0.
